// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch/timer datapath blocks.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Limit a loaded nibble (including non-BCD codes) to the digit's maximum.
  function automatic bcd_t bcd_clamp(bcd_t v, bcd_t max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One counter stage with its own maximum, up/down stepping, clear and clamped load.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  input  logic step,
  input  logic up,
  output bcd_t q,
  output logic term
);

  bcd_t nxt;

  always_comb begin
    nxt = q;
    if (clr) begin
      nxt = 4'd0;
    end else if (load) begin
      nxt = bcd_clamp(load_val, MAX);
    end else if (step) begin
      if (up) begin
        nxt = (q == MAX) ? 4'd0 : q + 4'd1;
      end else begin
        nxt = (q == 4'd0) ? MAX : q - 4'd1;
      end
    end else begin
      nxt = q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'd0;
    end else begin
      q <= nxt;
    end
  end

  // Terminal depends on direction so the ripple works for both up and down.
  assign term = up ? (q == MAX) : (q == 4'd0);

endmodule

// File: rtl/bcd_chain_counter.sv
// Chain of DIGITS BCD stages with per-digit maxima, wrap or saturate at the ends,
// and a combinational chain carry for cascading into the next block.
module bcd_chain_counter
  import stopwatch_pkg::*;
#(
  parameter int                  DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] DIGIT_MAX = {DIGITS{4'd9}},
  parameter bit                  SATURATE  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                carry,
  output logic                at_term
);

  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] step;
  logic              count_en;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_chain_counter: DIGITS must be within 1..8");
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (DIGIT_MAX[4*i +: 4] < 4'd1 || DIGIT_MAX[4*i +: 4] > BCD_MAX) begin : g_bad_max
      $error("bcd_chain_counter: every DIGIT_MAX nibble must be within 1..9");
    end

    // A digit steps only when every lower digit is at its terminal value.
    if (i == 0) begin : g_lsd
      assign step[i] = count_en;
    end else begin : g_upper
      assign step[i] = count_en & (&term[i-1:0]);
    end

    bcd_digit #(
      .MAX (DIGIT_MAX[4*i +: 4])
    ) u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[4*i +: 4]),
      .step     (step[i]),
      .up       (up),
      .q        (q[4*i +: 4]),
      .term     (term[i])
    );
  end

  assign at_term  = &term;
  assign count_en = enb & ~(SATURATE & at_term);
  assign carry    = enb & at_term & ~clr & ~load & ~rst & ~SATURATE;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Randomised and directed check of bcd_chain_counter against a mixed-radix integer model.
module tb_bcd_chain_counter;

  logic        clk = 1'b0;
  logic        rst, clr, load, enb, up;
  logic [15:0] load_val;
  logic [7:0]  q_a, q_c;
  logic [15:0] q_b;
  logic [11:0] q_d;
  logic        carry_a, carry_b, carry_c, carry_d;
  logic        at_term_a, at_term_b, at_term_c, at_term_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // A: 0-59 wrap, B: 0-9999 wrap, C: 0-59 saturate, D: odd maxima 3/7/5 wrap.
  localparam logic [31:0] MAXV [4] = '{32'h59, 32'h9999, 32'h59, 32'h375};
  localparam int          NDIG [4] = '{2, 4, 2, 3};
  localparam bit          SATV [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  bcd_chain_counter #(.DIGITS(2), .DIGIT_MAX(8'h59), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .enb(enb), .up(up), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .q(q_a), .carry(carry_a), .at_term(at_term_a));
  bcd_chain_counter #(.DIGITS(4)) u_b (
    .clk(clk), .rst(rst), .enb(enb), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .q(q_b), .carry(carry_b), .at_term(at_term_b));
  bcd_chain_counter #(.DIGITS(2), .DIGIT_MAX(8'h59), .SATURATE(1'b1)) u_c (
    .clk(clk), .rst(rst), .enb(enb), .up(up), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .q(q_c), .carry(carry_c), .at_term(at_term_c));
  bcd_chain_counter #(.DIGITS(3), .DIGIT_MAX(12'h375), .SATURATE(1'b0)) u_d (
    .clk(clk), .rst(rst), .enb(enb), .up(up), .clr(clr), .load(load),
    .load_val(load_val[11:0]), .q(q_d), .carry(carry_d), .at_term(at_term_d));

  logic [31:0] q_all [4];
  logic        t_all [4];
  logic        c_all [4];
  assign q_all[0] = {24'd0, q_a};
  assign q_all[1] = {16'd0, q_b};
  assign q_all[2] = {24'd0, q_c};
  assign q_all[3] = {20'd0, q_d};
  assign t_all[0] = at_term_a;
  assign t_all[1] = at_term_b;
  assign t_all[2] = at_term_c;
  assign t_all[3] = at_term_d;
  assign c_all[0] = carry_a;
  assign c_all[1] = carry_b;
  assign c_all[2] = carry_c;
  assign c_all[3] = carry_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int radix(int d, int i);
    logic [31:0] m;
    m = MAXV[d];
    return int'(m[4*i +: 4]) + 1;
  endfunction

  function automatic int total(int d);
    int t = 1;
    for (int i = 0; i < NDIG[d]; i++) t = t * radix(d, i);
    return t;
  endfunction

  function automatic logic [31:0] to_bcd(int d, int v);
    logic [31:0] r = 32'd0;
    int w = v;
    for (int i = 0; i < NDIG[d]; i++) begin
      r[4*i +: 4] = 4'(w % radix(d, i));
      w = w / radix(d, i);
    end
    return r;
  endfunction

  function automatic int from_bcd(int d, logic [31:0] lv);
    int v = 0;
    int n;
    for (int i = NDIG[d] - 1; i >= 0; i--) begin
      n = int'(lv[4*i +: 4]);
      if (n > radix(d, i) - 1) n = radix(d, i) - 1;
      v = v * radix(d, i) + n;
    end
    return v;
  endfunction

  // Model state: count as a plain integer in the block's mixed radix.
  int idx [4];
  bit valid = 1'b0;

  function automatic bit exp_term(int d, int v, logic dir);
    return dir ? (v == total(d) - 1) : (v == 0);
  endfunction

  function automatic int next_idx(int d, int v);
    if (rst || clr) return 0;
    if (load) return from_bcd(d, {16'd0, load_val});
    if (!enb) return v;
    if (up) begin
      if (v == total(d) - 1) return SATV[d] ? v : 0;
      return v + 1;
    end
    if (v == 0) return SATV[d] ? 0 : total(d) - 1;
    return v - 1;
  endfunction

  // Compare every DUT against the model, then advance the model with the inputs for the next edge.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (valid) begin
        chk($sformatf("model_q[%0d]", d), q_all[d], to_bcd(d, idx[d]));
        chk($sformatf("model_at_term[%0d]", d), {31'd0, t_all[d]},
            {31'd0, exp_term(d, idx[d], up)});
        chk($sformatf("model_carry[%0d]", d), {31'd0, c_all[d]},
            {31'd0, enb & exp_term(d, idx[d], up) & ~clr & ~load & ~rst & ~SATV[d]});
      end
      idx[d] <= next_idx(d, idx[d]);
    end
    if (rst) valid <= 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; enb = 1'b0; up = 1'b1; load_val = 16'd0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_q_b", {16'd0, q_b}, 32'h0);
    chk("reset_carry_b", {31'd0, carry_b}, 32'd0);
    chk("reset_at_term_up", {31'd0, at_term_a}, 32'd0);
    cyc();

    // Basic 0..59 count on A.
    rst = 1'b0; enb = 1'b1; up = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk("count_q_a", {24'd0, q_a}, 32'(((k / 10) << 4) | (k % 10)));
      chk("count_carry_a", {31'd0, carry_a}, {31'd0, (k == 59)});
    end
    @(negedge clk);
    chk("count_wrap_q_a", {24'd0, q_a}, 32'h0);
    cyc();

    // Down count through zero on B.
    load = 1'b1; load_val = 16'h0001; enb = 1'b0;
    cyc();
    load = 1'b0; up = 1'b0; enb = 1'b1;
    @(negedge clk); chk("down_q_0001", {16'd0, q_b}, 32'h0001);
    @(negedge clk); chk("down_q_0000", {16'd0, q_b}, 32'h0000);
    chk("down_carry", {31'd0, carry_b}, 32'd1);
    @(negedge clk); chk("down_q_9999", {16'd0, q_b}, 32'h9999);
    cyc();

    // Saturate on C.
    load = 1'b1; load_val = 16'h0058; enb = 1'b0; up = 1'b1;
    cyc();
    load = 1'b0; enb = 1'b1;
    @(negedge clk); chk("sat_q_58", {24'd0, q_c}, 32'h58);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sat_q_59", {24'd0, q_c}, 32'h59);
      chk("sat_at_term", {31'd0, at_term_c}, 32'd1);
      chk("sat_carry", {31'd0, carry_c}, 32'd0);
    end
    cyc();

    // Priority on B.
    load = 1'b1; load_val = 16'h0042; enb = 1'b0;
    cyc();
    load_val = 16'h7777; enb = 1'b1;
    @(negedge clk); chk("prio_q_0042", {16'd0, q_b}, 32'h0042);
    cyc();
    clr = 1'b1; enb = 1'b0;
    @(negedge clk); chk("prio_load_over_enb", {16'd0, q_b}, 32'h7777);
    cyc();
    rst = 1'b1; enb = 1'b1; up = 1'b0;
    @(negedge clk);
    chk("prio_clr_over_load", {16'd0, q_b}, 32'h0000);
    chk("prio_rst_carry", {31'd0, carry_b}, 32'd0);
    cyc();
    rst = 1'b0; clr = 1'b0; load = 1'b0; enb = 1'b0;
    @(negedge clk); chk("prio_rst_q", {16'd0, q_b}, 32'h0000);
    cyc();

    // Load clamping.
    load = 1'b1; load_val = 16'h00FC;
    cyc();
    load = 1'b0;
    @(negedge clk);
    chk("clamp_q_a", {24'd0, q_a}, 32'h59);
    chk("clamp_q_d", {20'd0, q_d}, 32'h075);
    cyc();

    // Enable gating and direction flip on B.
    clr = 1'b1;
    cyc();
    clr = 1'b0; enb = 1'b1; up = 1'b1;
    repeat (5) cyc();
    enb = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("gate_hold_0005", {16'd0, q_b}, 32'h0005);
      cyc();
    end
    enb = 1'b1; up = 1'b0;
    cyc();
    @(negedge clk); chk("flip_q_0004", {16'd0, q_b}, 32'h0004);
    cyc();

    // Randomised traffic, checked by the model on every cycle.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 7) == 0);
      enb      = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      load_val = 16'($urandom);
      cyc();
    end

    rst = 1'b0; clr = 1'b0; load = 1'b0; enb = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised multi-digit BCD counter for stopwatch and timer datapaths. It generalises the single decade stage to a chain of DIGITS stages, each with its own maximum value, so that ranges such as 0–59 and 0–9999 come from one block. It adds up/down counting, synchronous clear, parallel load, and an optional saturate mode. Its chain carry drives the next timebase stage, and its digits feed the display multiplexer.

## Interface
- DIGITS, 4, number of BCD digits; legal range 1–8.
- DIGIT_MAX, {DIGITS{4'd9}}, packed 4·DIGITS vector holding the per-digit maximum value (1–9). Digit 0 is in the LSBs. Example: 8'h59 for a 0–59 field.
- SATURATE, 0, selects end-of-range behaviour: 0 wraps at the terminal value, 1 holds at the terminal value.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enb  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 counts up, 0 counts down.
- clr  in  1  synchronous clear of all digits to 0.
- load  in  1  synchronous parallel load from load_val.
- load_val  in  4·DIGITS  load value, one BCD digit per nibble.
- q  out  4·DIGITS  current count, one BCD digit per nibble, registered.
- carry  out  1  chain carry/borrow, combinational; cascades into the next block's enb.
- at_term  out  1  combinational status: count equals the terminal value for the current direction.

## Operation
- Terminal value:
  - up=1: every digit i equals DIGIT_MAX[i].
  - up=0: every digit equals 0.
  - at_term reflects this regardless of enb.
- Update priority each clock edge: rst > clr > load > enb. With none of these active, q holds.
- rst and clr: q ← 0.
- load: each digit ← load_val digit, clamped. A nibble greater than DIGIT_MAX[i] (this includes non-BCD codes A–F) loads DIGIT_MAX[i].
- Counting, digit i:
  - Digit i steps when enb=1 and all digits below i are at their per-digit terminal for the current direction. Digit 0 steps whenever enb=1.
  - Up: a digit at DIGIT_MAX[i] goes to 0; otherwise it adds 1.
  - Down: a digit at 0 goes to DIGIT_MAX[i]; otherwise it subtracts 1.
- Whole-chain wrap (SATURATE=0):
  - Up from all-max gives all zeros.
  - Down from all zeros gives all-max.
- Saturate (SATURATE=1): with at_term=1 and enb=1, q holds.
- carry = enb & at_term & ~clr & ~load & ~rst & (SATURATE==0).
  - Asserted exactly in the cycle whose edge performs the whole-chain wrap.
  - Never asserted in saturate mode.
- A direction change takes effect on the next enabled step. There is no extra latency and no lost step.

## Timing
- Reset value: q=0. With up=1, at_term reads 0 unless every DIGIT_MAX digit is 0, which is illegal. With up=0, at_term=1. carry=0 while rst is high.
- Latency: a change on enb, clr, or load becomes visible on q one cycle later.
- carry and at_term are combinational from q, enb, up, clr, load, and rst. Their valid window is the same cycle as the inputs. There is no registered delay, so a chain of blocks steps in lockstep.
- clr and load asserted together: clr wins.
- load and enb asserted together: the load value is taken and no step is applied.
- rst in mid-count: q=0 at the next edge. No partial state is retained.

## Structure
- Shared package `stopwatch_pkg`:
  - `bcd_t` (logic [3:0]).
  - `BCD_MAX` = 4'd9.
  - Function `bcd_clamp(bcd_t v, bcd_t max)`.
- One sub-module `bcd_digit`: one stage with per-digit max, up/down, load, clear, a step-enable input, and a terminal-flag output. A generate loop instantiates DIGITS copies. The top level builds the ripple of per-digit terminal flags into the step enables, then computes at_term and carry.
- Elaboration assertions:
  - DIGITS is within 1–8.
  - Every DIGIT_MAX nibble is within 1–9.

## Test plan
- Basic count: DIGITS=2, DIGIT_MAX=8'h59, up=1, enb=1 from reset for 60 cycles. Required: q steps 00,01…09,10…59,00. carry=1 only in the cycle q=59. at_term=1 in that same cycle.
- Down count with wrap: DIGITS=4, default max, load 16'h0001, then up=0, enb=1. Required: q goes 0001→0000→9999. carry=1 in the q=0000 cycle.
- Saturate: SATURATE=1, DIGIT_MAX=8'h59, load 8'h58, up=1, enb=1 for 3 cycles. Required: q=59 and holds. carry=0 throughout. at_term=1 from the cycle q=59 onward.
- Priority: with q=0042 (DIGITS=4), apply load 16'h7777 plus enb in one cycle. Required: q=7777. Then apply clr+load. Required: q=0000. Then apply rst+clr+load+enb. Required: q=0000 and carry=0.
- Load clamping: DIGIT_MAX=8'h59, load 8'hFC. Required: q=59.
- Enable gating and direction flip: count up to 0005, drop enb for 4 cycles, then resume with up=0. Required: q holds at 0005 for exactly 4 cycles, then 0004 on the first enabled edge.
